pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush generator driving the F/D, D/E, E/M and M/W pipeline registers.
//  Arbitrates AXI fetch/data waits, load-use hazards, multi-cycle divide and M-stage exceptions.
//  Drops the fetch that is in flight when an exception is taken, then redirects the PC.
//  Sits beside the datapath. Pipeline registers apply clear before stall.
// PARAMETERS
//  DIV_CYCLES  32                         stall cycles for one divide, >=2
//  CNT_W       $clog2(DIV_CYCLES)         divide counter width
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  i_stall_req  in   1  AXI instruction fetch outstanding
//  d_stall_req  in   1  AXI data access of the M-stage instruction outstanding
//  lu_hazardD   in   1  load-use hazard detected in D
//  div_startE   in   1  divide instruction present in E
//  exc_M        in   1  exception/eret committed by the M-stage instruction
//  stallF/D/E/M out  1  hold the PC / F-D / D-E / E-M register
//  flushD/E/M/W out  1  clear the F-D / D-E / E-M / M-W register
//  exc_redirect out  1  load the exception/eret target into the PC this cycle
//  div_busy     out  1  divide stall active
//  div_cancel   out  1  one-cycle pulse: the divide in E was killed by an exception
// BEHAVIOUR
//  State: RUN, DIV, DRAIN (2-bit enum), plus cnt[CNT_W]. Async reset -> RUN, cnt=0.
//  All outputs are combinational from state, cnt and inputs. They read 0 while rst=0.
//  Priority, first match wins:
//   1 exc_M & !d_stall_req & state!=DRAIN
//     - flushD=flushE=flushM=1. Go to RUN, cnt=0.
//     - If state==DIV or div_startE: div_cancel=1.
//     - If i_stall_req: stallF=1, exc_redirect=0, next state DRAIN.
//     - Otherwise exc_redirect=1, stallF=0.
//   2 DRAIN
//     - flushD=1, exc_M ignored, all other stalls 0.
//     - While i_stall_req: stallF=1.
//     - When i_stall_req=0: stallF=0, exc_redirect=1, next state RUN.
//   3 d_stall_req: stallF=stallD=stallE=stallM=1, flushW=1.
//     d_stall_req always beats exc_M. The exception is taken on the first cycle d_stall_req is low.
//   4 divide active: stallF=stallD=stallE=1, flushM=1, div_busy=1.
//     - Active when (state==RUN & div_startE) or (state==DIV & cnt!=0).
//   5 lu_hazardD: stallF=stallD=1, flushE=1.
//   6 i_stall_req: stallF=1, flushD=1.
//   7 otherwise every stall and flush is 0.
//  Divide timing (state updates independent of the output priority):
//   - RUN & div_startE & no exception at cycle t: DIV with cnt=DIV_CYCLES-1 at t+1.
//   - In DIV, cnt decrements every cycle, also under d_stall_req, and saturates at 0.
//   - DIV & cnt==0 & !d_stall_req: the divide stall is released that cycle, next state RUN.
//   - div_startE is ignored while in DIV. The divide in E advances on the release cycle and is not restarted.
//   - Total divide stall = exactly DIV_CYCLES cycles when no other event occurs.
//  Simultaneous events:
//   - Lower-priority requests are masked, never queued. Stall inputs are level-held.
//   - lu_hazardD during a divide stall: the divide outputs win. No extra flushE.
//   - An exception in DIV kills the divide: cnt=0 immediately, div_cancel pulses.
//  Reset mid-operation: state and counter clear asynchronously. No pulse survives reset.
// STRUCTURE
//  Shared package:
//   - pipe_ctrl_state_t enum {RUN, DIV, DRAIN}
//   - stall_flush_t packed struct {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}, exported as a single port bundle
//   - DIV_CYCLES_DEFAULT constant
//  Sub-module div_stall_counter:
//   - load/decrement/saturate counter, outputs busy and done
//   - instantiated once
// TESTING
//  i_stall_req=1 for 3 cycles, nothing else -> stallF=1, flushD=1 for 3 cycles. All else 0.
//  div_startE=1 with DIV_CYCLES=32 -> stallF/D/E=1, flushM=1 for exactly 32 cycles. Release on the 32nd.
//  Divide in flight, cnt=10, exc_M=1 -> flushD/E/M=1, div_cancel=1 pulse, exc_redirect=1. Next cycle RUN, no stall.
//  exc_M with i_stall_req=1 for 4 more cycles -> stallF=1, flushD=1 through the drain.
//    exc_redirect=1 on the first cycle i_stall_req=0, exactly once.
//  d_stall_req=1, lu_hazardD=1, i_stall_req=1 together -> only stallF/D/E/M=1, flushW=1.
//    When d_stall_req drops, lu_hazardD outputs appear.
//  Assert rst=0 mid-divide with cnt=5 -> all outputs 0 at once. After release, RUN, cnt=0, no stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and the stall/flush bundle.
// Types and constants only; no latency or backpressure of its own.
package pipeline_ctrl_pkg;

  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    DRAIN = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushM;
    logic flushW;
  } stall_flush_t;

endpackage

// File: rtl/pipeline_ctrl_div_stall_counter.sv
// Divide stall counter: load to DIV_CYCLES-1, decrement to a saturating zero, clear on exception.
// One cycle from load to busy; never blocks, clear beats load beats decrement.
module pipeline_ctrl_div_stall_counter #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic busy_o,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(DIV_CYCLES - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush generator: fetch/data waits, load-use, multi-cycle divide, M-stage exceptions.
// Outputs are combinational from state and inputs (zero latency); all outputs read 0 in reset.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_stall_req,
  input  logic         d_stall_req,
  input  logic         lu_hazardD,
  input  logic         div_startE,
  input  logic         exc_M,
  output stall_flush_t stall_flush,
  output logic         exc_redirect,
  output logic         div_busy,
  output logic         div_cancel
);

  pipe_ctrl_state_t state_q, state_d;
  stall_flush_t     sf_c;
  logic             redir_c, busy_c, cancel_c;
  logic             exc_take, div_act, cnt_busy, cnt_done;

  // An exception waits for the M-stage data access and never re-enters during a drain.
  assign exc_take = exc_M && !d_stall_req && (state_q != DRAIN);
  assign div_act  = ((state_q == RUN) && div_startE) || ((state_q == DIV) && cnt_busy);

  pipeline_ctrl_div_stall_counter #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_div_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (exc_take),
    .load_i((state_q == RUN) && div_startE),
    .dec_i (state_q == DIV),
    .busy_o(cnt_busy),
    .done_o(cnt_done)
  );

  always_comb begin
    state_d = state_q;
    if (exc_take) begin
      state_d = i_stall_req ? DRAIN : RUN;
    end else begin
      case (state_q)
        RUN:     if (div_startE) state_d = DIV;
        DIV:     if (cnt_done && !d_stall_req) state_d = RUN;
        DRAIN:   if (!i_stall_req) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sf_c     = '0;
    redir_c  = 1'b0;
    busy_c   = 1'b0;
    cancel_c = 1'b0;
    if (exc_take) begin
      sf_c.flushD = 1'b1;
      sf_c.flushE = 1'b1;
      sf_c.flushM = 1'b1;
      cancel_c    = (state_q == DIV) || div_startE;
      sf_c.stallF = i_stall_req;
      redir_c     = !i_stall_req;
    end else if (state_q == DRAIN) begin
      // Kill whatever the in-flight fetch returns, redirect once it is gone.
      sf_c.flushD = 1'b1;
      sf_c.stallF = i_stall_req;
      redir_c     = !i_stall_req;
    end else if (d_stall_req) begin
      sf_c.stallF = 1'b1;
      sf_c.stallD = 1'b1;
      sf_c.stallE = 1'b1;
      sf_c.stallM = 1'b1;
      sf_c.flushW = 1'b1;
    end else if (div_act) begin
      sf_c.stallF = 1'b1;
      sf_c.stallD = 1'b1;
      sf_c.stallE = 1'b1;
      sf_c.flushM = 1'b1;
      busy_c      = 1'b1;
    end else if (lu_hazardD) begin
      sf_c.stallF = 1'b1;
      sf_c.stallD = 1'b1;
      sf_c.flushE = 1'b1;
    end else if (i_stall_req) begin
      sf_c.stallF = 1'b1;
      sf_c.flushD = 1'b1;
    end
  end

  assign stall_flush  = rst ? sf_c : '0;
  assign exc_redirect = rst && redir_c;
  assign div_busy     = rst && busy_c;
  assign div_cancel   = rst && cancel_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a cycle-count based reference model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_stall_req = 1'b0, d_stall_req = 1'b0, lu_hazardD = 1'b0, div_startE = 1'b0, exc_M = 1'b0;
  stall_flush_t stall_flush;
  logic exc_redirect, div_busy, div_cancel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall_req (i_stall_req),
    .d_stall_req (d_stall_req),
    .lu_hazardD  (lu_hazardD),
    .div_startE  (div_startE),
    .exc_M       (exc_M),
    .stall_flush (stall_flush),
    .exc_redirect(exc_redirect),
    .div_busy    (div_busy),
    .div_cancel  (div_cancel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a divide started at cycle t0 stalls while cyc < t0+DIVC, then lingers
  // (no stall) until a cycle without a data stall lets it retire.
  logic m_in_div, m_drain;
  int   m_t0, cyc;
  logic exc_now;
  assign exc_now = exc_M && !d_stall_req && !m_drain;

  function automatic logic [10:0] model_out();
    logic [7:0] s;
    logic r, b, c, dv;
    s = 8'h00; r = 1'b0; b = 1'b0; c = 1'b0;
    dv = m_in_div ? (cyc < m_t0 + DIVC) : (!m_drain && div_startE);
    if (exc_now) begin
      s = 8'h0E;
      c = m_in_div || div_startE;
      if (i_stall_req) s[7] = 1'b1; else r = 1'b1;
    end else if (m_drain) begin
      s = 8'h08;
      if (i_stall_req) s[7] = 1'b1; else r = 1'b1;
    end else if (d_stall_req) s = 8'hF1;
    else if (dv) begin s = 8'hE2; b = 1'b1; end
    else if (lu_hazardD) s = 8'hC4;
    else if (i_stall_req) s = 8'h88;
    return {s, r, b, c};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in_div <= 1'b0; m_drain <= 1'b0; m_t0 <= 0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (exc_now) begin
        m_in_div <= 1'b0;
        m_drain  <= i_stall_req;
      end else if (m_drain) begin
        m_drain <= i_stall_req;
      end else if (m_in_div) begin
        if (cyc >= m_t0 + DIVC && !d_stall_req) m_in_div <= 1'b0;
      end else if (div_startE) begin
        m_in_div <= 1'b1;
        m_t0     <= cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) chk("reset_outputs", {stall_flush, exc_redirect, div_busy, div_cancel}, 11'h0);
    else chk($sformatf("cycle%0d", cyc), {stall_flush, exc_redirect, div_busy, div_cancel}, model_out());
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic is, input logic ds, input logic lu, input logic dv, input logic ex);
    i_stall_req = is; d_stall_req = ds; lu_hazardD = lu; div_startE = dv; exc_M = ex;
  endtask

  initial begin
    int n;
    int nredir;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sf", stall_flush, 8'h00);
    next_cycle();
    rst = 1'b1;

    // Fetch wait alone.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0);
      @(negedge clk); chk("istall_sf", stall_flush, 8'h88);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); chk("istall_off", stall_flush, 8'h00);
    next_cycle();

    // Plain divide length.
    set_in(0, 0, 0, 1, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall_flush == 8'hE2 && div_busy) n++;
      else break;
      next_cycle();
    end
    chk("div_len", n, DIVC);
    chk("div_release", {stall_flush, div_busy}, 9'h0);
    next_cycle();
    set_in(0, 0, 0, 0, 0);
    next_cycle();

    // Exception kills a divide with cnt=10.
    set_in(0, 0, 0, 1, 0);
    repeat (22) next_cycle();
    exc_M = 1'b1;
    @(negedge clk);
    chk("exc_div_sf", stall_flush, 8'h0E);
    chk("exc_div_redir", exc_redirect, 1);
    chk("exc_div_cancel", div_cancel, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); chk("exc_div_after", {stall_flush, div_busy, div_cancel}, 10'h0);
    next_cycle();

    // Exception during a fetch wait drains it first.
    nredir = 0;
    set_in(1, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain_first_sf", stall_flush, 8'h8E);
    nredir += int'(exc_redirect);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, i[0]);
      @(negedge clk); chk("drain_sf", stall_flush, 8'h88);
      nredir += int'(exc_redirect);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_end_sf", stall_flush, 8'h08);
    nredir += int'(exc_redirect);
    next_cycle();
    @(negedge clk);
    nredir += int'(exc_redirect);
    chk("drain_redirects", nredir, 1);
    next_cycle();

    // Data wait masks everything; hazard shows once it drops.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 1, 0, 0);
      @(negedge clk); chk("dstall_sf", stall_flush, 8'hF1);
      next_cycle();
    end
    set_in(1, 0, 1, 0, 0);
    @(negedge clk); chk("lu_after_dstall", stall_flush, 8'hC4);
    next_cycle();

    // Exception held back by a data wait.
    set_in(0, 1, 0, 0, 1);
    @(negedge clk); chk("exc_blocked", {stall_flush, exc_redirect}, {8'hF1, 1'b0});
    next_cycle();
    set_in(0, 0, 0, 0, 1);
    @(negedge clk); chk("exc_taken", {stall_flush, exc_redirect}, {8'h0E, 1'b1});
    next_cycle();
    set_in(0, 0, 0, 0, 0);
    next_cycle();

    // Asynchronous reset mid-divide at cnt=5.
    set_in(0, 0, 0, 1, 0);
    repeat (27) next_cycle();
    chk("pre_rst_busy", div_busy, 1);
    #2 rst = 1'b0;
    #1 chk("rst_now", {stall_flush, exc_redirect, div_busy, div_cancel}, 11'h0);
    div_startE = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk("post_rst", {stall_flush, div_busy}, 9'h0);
    next_cycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
             ($urandom % 8) == 0, ($urandom % 12) == 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
